// File: rtl/gf_inverse_seq.sv
// Sequential GF(2^13) inverter: b = a^(2^13-2) by repeated square-and-multiply, valid/ready on both sides.
// Define GF_INV_TWO_STEP_EN to chain two square/multiply stages per cycle and halve the latency.
module gf_inverse_seq (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [12:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [12:0]   out_data,
    output logic          out_zero,
    output logic          busy
);
    localparam int unsigned M     = 13;
    localparam int unsigned STEPS = M - 1;
    localparam int unsigned CW    = 4;
    localparam int unsigned PW    = 2 * M - 1;
    localparam logic [M:0]  POLY  = 14'h201B;  // x^13 + x^4 + x^3 + x + 1
`ifdef GF_INV_TWO_STEP_EN
    localparam int unsigned STEP_INC = 2;
`else
    localparam int unsigned STEP_INC = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Fold a raw carry-less product back into the field, top bit first.
    function automatic logic [M-1:0] reduce(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = p;
        for (int i = int'(PW) - 1; i >= int'(M); i--) begin
            if (r[i]) r[i -: M+1] = r[i -: M+1] ^ POLY;
        end
        return r[M-1:0];
    endfunction

    function automatic logic [M-1:0] pb_mult_new(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [PW-1:0] p;
        p = '0;
        for (int j = 0; j < int'(M); j++) begin
            if (b[j]) p = p ^ (PW'(a) << j);
        end
        return reduce(p);
    endfunction

    // Squaring in characteristic 2 only spreads the bits before reduction.
    function automatic logic [M-1:0] square(input logic [M-1:0] a);
        logic [PW-1:0] p;
        p = '0;
        for (int j = 0; j < int'(M); j++) p[2*j] = a[j];
        return reduce(p);
    endfunction

    state_t         state, state_next;
    logic [M-1:0]   sq, sq_next, acc, acc_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [M-1:0]   out_data_next;
    logic           out_zero_next, out_valid_next, in_ready_next, busy_next;
    logic [M-1:0]   s1, prod1, step_sq, step_acc;
`ifdef GF_INV_TWO_STEP_EN
    logic [M-1:0]   s2, prod2;
`endif

    // Datapath for one RUN cycle.
    always_comb begin
        s1    = square(sq);
        prod1 = pb_mult_new(acc, s1);
`ifdef GF_INV_TWO_STEP_EN
        s2       = square(s1);
        prod2    = pb_mult_new(prod1, s2);
        step_sq  = s2;
        step_acc = prod2;
`else
        step_sq  = s1;
        step_acc = prod1;
`endif
    end

    // Next-state and register-input logic; flush overrides every transition.
    always_comb begin
        state_next     = state;
        sq_next        = sq;
        acc_next       = acc;
        cnt_next       = cnt;
        out_data_next  = out_data;
        out_zero_next  = out_zero;
        out_valid_next = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sq_next       = in_data;
                    acc_next      = M'(1);
                    cnt_next      = '0;
                    out_zero_next = (in_data == '0);
                    state_next    = RUN;
                end
            end
            RUN: begin
                sq_next  = step_sq;
                acc_next = step_acc;
                cnt_next = cnt + CW'(STEP_INC);
                if (cnt == CW'(STEPS - STEP_INC)) begin
                    state_next     = DONE;
                    out_data_next  = step_acc;
                    out_valid_next = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            cnt_next       = '0;
            sq_next        = sq;
            acc_next       = acc;
            out_data_next  = out_data;
            out_zero_next  = out_zero;
        end
        in_ready_next = (state_next == IDLE);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sq        <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            sq        <= sq_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_data  <= out_data_next;
            out_zero  <= out_zero_next;
            out_valid <= out_valid_next;
            in_ready  <= in_ready_next;
            busy      <= busy_next;
        end
    end
endmodule

// File: tb/tb_gf_inverse_seq.sv
// Directed + random bench for gf_inverse_seq with a queue scoreboard and an independent field model.
module tb_gf_inverse_seq;
`ifdef GF_INV_TWO_STEP_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 12;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_data;
    logic        out_zero;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_data_q[$];
    logic        exp_zero_q[$];

    always #5 clk = ~clk;

    gf_inverse_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .busy(busy)
    );

    // Shift-and-add multiply with reduction after every shift.
    function automatic logic [12:0] mul(input logic [12:0] a, input logic [12:0] b);
        logic [13:0] x;
        logic [12:0] r;
        x = {1'b0, a};
        r = '0;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) r = r ^ x[12:0];
            x = x << 1;
            if (x[13]) x = x ^ 14'h201B;
        end
        return r;
    endfunction

    // a^(8190) by left-to-right square-and-multiply.
    function automatic logic [12:0] model_inv(input logic [12:0] a);
        logic [12:0] e;
        logic [12:0] r;
        e = 13'h1FFE;
        r = 13'h0001;
        for (int i = 12; i >= 0; i--) begin
            r = mul(r, r);
            if (e[i]) r = mul(r, a);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [12:0] a);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("in_ready_before_start", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = a;
        step();
        in_valid = 1'b0;
        in_data  = 13'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin step(); cyc++; end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic pop_compare(input string tag);
        logic [12:0] ed;
        logic        ez;
        if (exp_data_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            ed = exp_data_q.pop_front();
            ez = exp_zero_q.pop_front();
            check({tag, "_data"}, 32'(out_data), 32'(ed));
            check({tag, "_zero"}, 32'(out_zero), 32'(ez));
        end
    endtask

    // Full transaction with out_ready held high.
    task automatic run_op(input string tag, input logic [12:0] a, input bit chk_lat, input bit chk_prod);
        int c;
        exp_data_q.push_back(model_inv(a));
        exp_zero_q.push_back(a == '0);
        start(a);
        wait_valid(c);
        if (chk_lat) check({tag, "_latency"}, 32'(c), 32'(LAT));
        pop_compare(tag);
        if (chk_prod) check({tag, "_a_times_inv"}, 32'(mul(a, out_data)), 32'd1);
        step();
        if (chk_lat) begin
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int c;
        int seen;
        logic [12:0] a;
        logic [12:0] held;

        // Reset, then idle
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data", 32'(out_data), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed operands
        run_op("one", 13'h0001, 1'b1, 1'b1);
        run_op("x", 13'h0002, 1'b1, 1'b1);
        check("x_known_inverse", 32'(out_data), 32'h100D);
        run_op("zero", 13'h0000, 1'b1, 1'b0);
        run_op("top", 13'h1FFF, 1'b1, 1'b1);

        // Random nonzero operands
        for (int i = 0; i < 200; i++) begin
            a = 13'($urandom_range(1, 8191));
            run_op("rand", a, 1'b0, 1'b1);
        end

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        exp_data_q.push_back(model_inv(13'h1234));
        exp_zero_q.push_back(1'b0);
        start(13'h1234);
        wait_valid(c);
        check("bp_latency", 32'(c), 32'(LAT));
        held = out_data;
        pop_compare("bp");
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_data_hold", 32'(out_data), 32'(model_inv(13'h1234)));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_data_held", 32'(out_data), 32'(held));

        // Flush colliding with the output handshake
        out_ready = 1'b0;
        start(13'h0777);
        wait_valid(c);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("fhs_valid", 32'(out_valid), 32'd0);
        check("fhs_in_ready", 32'(in_ready), 32'd1);
        check("fhs_data_held", 32'(out_data), 32'(model_inv(13'h0777)));

        // Flush with in_valid: operand must not be taken
        in_valid = 1'b1;
        in_data = 13'h0005;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_in_ready", 32'(in_ready), 32'd1);

        // Flush on RUN cycle 5
        start(13'h0AAA);
        repeat (4) step();
        check("frun_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("frun_busy", 32'(busy), 32'd0);
        check("frun_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("frun_no_result", 32'(seen), 32'd0);

        // Asynchronous reset mid-RUN
        start(13'h0BBB);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("arst_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 13'h0002, 1'b1, 1'b1);
        check("after_abort_value", 32'(out_data), 32'h100D);

        check("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
